// File: rtl/wb_pkg.sv
// Shared limits and the round-robin grant helper for the write-back arbiter.
// Entry layout lives in wb_arbiter because its field widths follow that module's parameters.
package wb_pkg;

   localparam int WB_MAX_SRC   = 8;
   localparam int WB_MAX_DEPTH = 16;
   localparam int WB_SRC_IDX_W = $clog2(WB_MAX_SRC);

   // Returns the first requesting source after 'last' (cyclic). With no request it returns 'last'.
   function automatic int unsigned wb_rr_next(input logic [WB_MAX_SRC-1:0] req,
                                              input int unsigned           last,
                                              input int unsigned           num_src);
      int unsigned idx;
      int unsigned win;
      logic        found;
      win   = last;
      found = 1'b0;
      for (int unsigned i = 1; i <= WB_MAX_SRC; i++) begin
         idx = last + i;
         if (idx >= num_src) idx = idx - num_src;
         if (!found && (i <= num_src) && req[idx[WB_SRC_IDX_W-1:0]]) begin
            win   = idx;
            found = 1'b1;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/wb_arbiter_fifo.sv
// In-order FIFO, zero-latency read of the head; push on full is taken only alongside a pop.
// Exposes per-slot valid bits and the top VIEW_W bits of every slot for the pending mask.
module sync_fifo #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 4,
   parameter int VIEW_W = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_push,
   input  logic                    i_pop,
   input  logic [WIDTH-1:0]        i_wdata,
   output logic [WIDTH-1:0]        o_rdata,
   output logic                    o_full,
   output logic                    o_empty,
   output logic [$clog2(DEPTH):0]  o_count,
   output logic [DEPTH-1:0]        o_valid,
   output logic [DEPTH*VIEW_W-1:0] o_view
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic [DEPTH-1:0] r_valid;
   logic [DEPTH-1:0] w_valid_nxt;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_valid = r_valid;
   assign o_rdata = r_mem[r_rd_ptr];
   assign w_pop   = i_pop && !o_empty;
   assign w_push  = i_push && (!o_full || w_pop);

   // Clear before set so a push+pop on a full FIFO keeps the shared slot valid.
   always_comb begin
      w_valid_nxt = r_valid;
      if (w_pop)  w_valid_nxt[r_rd_ptr] = 1'b0;
      if (w_push) w_valid_nxt[r_wr_ptr] = 1'b1;
   end

   always_comb begin
      o_view = '0;
      for (int k = 0; k < DEPTH; k++) begin
         o_view[k*VIEW_W +: VIEW_W] = r_mem[k][WIDTH-1 -: VIEW_W];
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_valid  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         r_valid <= w_valid_nxt;
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin write-back arbiter feeding an in-order FIFO and a registered bank-write stage.
// Accept-to-write-enable is 2 cycles; ready drops when full unless a pop frees a slot this cycle.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter  int DATA_WIDTH   = 32,
   parameter  int NUM_REG      = 32,
   parameter  int NUM_SRC      = 2,
   parameter  int DEPTH        = 4,
   localparam int SELECT_WIDTH = $clog2(NUM_REG)
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [NUM_SRC-1:0]                     i_valid,
   input  logic [NUM_SRC-1:0][SELECT_WIDTH-1:0]   i_select,
   input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]     i_data,
   output logic [NUM_SRC-1:0]                     o_ready,
   input  logic                                   i_hold,
   output logic                                   o_write_enable,
   output logic [SELECT_WIDTH-1:0]                o_write_select,
   output logic [DATA_WIDTH-1:0]                  o_write_data,
   output logic [NUM_REG-1:0]                     o_pending,
   output logic                                   o_full
);
   localparam int LAST_W = $clog2(NUM_SRC);
   localparam int CNT_W  = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [SELECT_WIDTH-1:0] select;
      logic [DATA_WIDTH-1:0]   data;
   } wb_entry_t;
   localparam int ENTRY_W = $bits(wb_entry_t);

   logic [LAST_W-1:0]             r_last;
   logic [LAST_W-1:0]             w_gidx;
   logic                          w_any_req;
   logic                          w_space;
   logic                          w_accept;
   logic                          w_in_range;
   logic                          w_push;
   logic                          w_pop;
   wb_entry_t                     w_in;
   wb_entry_t                     w_out;
   logic                          w_full;
   logic                          w_empty;
   logic [CNT_W-1:0]              w_count;
   logic [DEPTH-1:0]              w_valid;
   logic [DEPTH*SELECT_WIDTH-1:0] w_view;
   logic                          r_write_enable;
   logic [SELECT_WIDTH-1:0]       r_write_select;
   logic [DATA_WIDTH-1:0]         r_write_data;
   logic [NUM_REG-1:0]            w_pending;

   assign w_gidx    = LAST_W'(wb_rr_next(WB_MAX_SRC'(i_valid), int'(r_last), NUM_SRC));
   assign w_any_req = |i_valid;
   assign w_pop     = !w_empty && !i_hold;
   assign w_space   = !w_full || w_pop;
   assign w_accept  = rst_n && w_any_req && w_space;

   always_comb begin
      o_ready = '0;
      if (w_accept) o_ready[w_gidx] = 1'b1;
   end

   always_comb begin
      w_in.select = i_select[w_gidx];
      w_in.data   = i_data[w_gidx];
   end

   // Out-of-range selects still complete the handshake; they are simply dropped here.
   assign w_in_range = ({1'b0, w_in.select} < (SELECT_WIDTH+1)'(NUM_REG));
   assign w_push     = w_accept && w_in_range;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last <= LAST_W'(NUM_SRC - 1);
      end else if (w_accept) begin
         r_last <= w_gidx;
      end
   end

   sync_fifo #(
      .WIDTH  (ENTRY_W),
      .DEPTH  (DEPTH),
      .VIEW_W (SELECT_WIDTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata (w_in),
      .o_rdata (w_out),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count),
      .o_valid (w_valid),
      .o_view  (w_view)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_write_enable <= 1'b0;
         r_write_select <= '0;
         r_write_data   <= '0;
      end else begin
         r_write_enable <= w_pop;
         if (w_pop) begin
            r_write_select <= w_out.select;
            r_write_data   <= w_out.data;
         end
      end
   end

   always_comb begin
      w_pending = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (w_valid[k]) w_pending = w_pending | (NUM_REG'(1) << w_view[k*SELECT_WIDTH +: SELECT_WIDTH]);
      end
      if (r_write_enable) w_pending = w_pending | (NUM_REG'(1) << r_write_select);
   end

   assign o_write_enable = r_write_enable;
   assign o_write_select = r_write_select;
   assign o_write_data   = r_write_data;
   assign o_pending      = w_pending;
   assign o_full         = (w_count == CNT_W'(DEPTH));

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with NUM_REG=24, NUM_SRC=2, DEPTH=4: vector table plus
// hand sequences for hold/full, same-register ordering and mid-operation reset.
module tb_wb_arbiter;

   logic             clk;
   logic             rst_n;
   logic [1:0]       valid;
   logic [1:0][4:0]  sel;
   logic [1:0][31:0] dat;
   logic [1:0]       ready;
   logic             hold;
   logic             we;
   logic [4:0]       wsel;
   logic [31:0]      wdat;
   logic [23:0]      pend;
   logic             full;

   int n_cmp;
   int n_bad;

   wb_arbiter #(
      .DATA_WIDTH (32),
      .NUM_REG    (24),
      .NUM_SRC    (2),
      .DEPTH      (4)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_valid        (valid),
      .i_select       (sel),
      .i_data         (dat),
      .o_ready        (ready),
      .i_hold         (hold),
      .o_write_enable (we),
      .o_write_select (wsel),
      .o_write_data   (wdat),
      .o_pending      (pend),
      .o_full         (full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic        rst;
      logic [1:0]  valid;
      logic [4:0]  s0;
      logic [4:0]  s1;
      logic [31:0] d0;
      logic [31:0] d1;
      logic        hold;
      logic [1:0]  e_rdy;
      logic        e_we;
      logic [4:0]  e_sel;
      logic [31:0] e_dat;
      logic [23:0] e_pend;
      logic        e_full;
   } vec_t;

   vec_t tbl [18];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 'h%0h, want 'h%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      valid = 2'b00;
      hold  = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   logic [4:0]  got_sel [$];
   logic [31:0] got_dat [$];
   logic [4:0]  mid_sel [4];
   int          k;
   int          nw;
   int          bad_we;
   logic        acc;

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      valid = 2'b00;
      hold  = 1'b0;
      sel   = '0;
      dat   = '0;

      //          rst   valid  s0     s1     d0            d1        hold   rdy    we    sel    data          pend        full
      tbl[0]  = '{1'b1, 2'b00, 5'd0,  5'd0,  32'h0,        32'h0,    1'b0, 2'b00, 1'b0, 5'd0, 32'h0,        24'h000000, 1'b0};
      tbl[1]  = '{1'b0, 2'b01, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,    1'b0, 2'b01, 1'b0, 5'd0, 32'h0,        24'h000000, 1'b0};
      tbl[2]  = '{1'b0, 2'b00, 5'd0,  5'd0,  32'h0,        32'h0,    1'b0, 2'b00, 1'b0, 5'd0, 32'h0,        24'h000020, 1'b0};
      tbl[3]  = '{1'b0, 2'b00, 5'd0,  5'd0,  32'h0,        32'h0,    1'b0, 2'b00, 1'b1, 5'd5, 32'hDEADBEEF, 24'h000020, 1'b0};
      tbl[4]  = '{1'b0, 2'b00, 5'd0,  5'd0,  32'h0,        32'h0,    1'b0, 2'b00, 1'b0, 5'd5, 32'hDEADBEEF, 24'h000000, 1'b0};
      tbl[5]  = '{1'b1, 2'b00, 5'd0,  5'd0,  32'h0,        32'h0,    1'b0, 2'b00, 1'b0, 5'd0, 32'h0,        24'h000000, 1'b0};
      tbl[6]  = '{1'b0, 2'b11, 5'd1,  5'd2,  32'h11,       32'h22,   1'b0, 2'b01, 1'b0, 5'd0, 32'h0,        24'h000000, 1'b0};
      tbl[7]  = '{1'b0, 2'b11, 5'd1,  5'd2,  32'h11,       32'h22,   1'b0, 2'b10, 1'b0, 5'd0, 32'h0,        24'h000002, 1'b0};
      tbl[8]  = '{1'b0, 2'b11, 5'd1,  5'd2,  32'h11,       32'h22,   1'b0, 2'b01, 1'b1, 5'd1, 32'h11,       24'h000006, 1'b0};
      tbl[9]  = '{1'b0, 2'b11, 5'd1,  5'd2,  32'h11,       32'h22,   1'b0, 2'b10, 1'b1, 5'd2, 32'h22,       24'h000006, 1'b0};
      tbl[10] = '{1'b0, 2'b11, 5'd1,  5'd2,  32'h11,       32'h22,   1'b0, 2'b01, 1'b1, 5'd1, 32'h11,       24'h000006, 1'b0};
      tbl[11] = '{1'b0, 2'b00, 5'd1,  5'd2,  32'h11,       32'h22,   1'b0, 2'b00, 1'b1, 5'd2, 32'h22,       24'h000006, 1'b0};
      tbl[12] = '{1'b0, 2'b00, 5'd1,  5'd2,  32'h11,       32'h22,   1'b0, 2'b00, 1'b1, 5'd1, 32'h11,       24'h000002, 1'b0};
      tbl[13] = '{1'b0, 2'b00, 5'd1,  5'd2,  32'h11,       32'h22,   1'b0, 2'b00, 1'b0, 5'd1, 32'h11,       24'h000000, 1'b0};
      tbl[14] = '{1'b0, 2'b10, 5'd0,  5'd30, 32'h0,        32'h33,   1'b0, 2'b10, 1'b0, 5'd1, 32'h11,       24'h000000, 1'b0};
      tbl[15] = '{1'b0, 2'b01, 5'd24, 5'd0,  32'h44,       32'h0,    1'b0, 2'b01, 1'b0, 5'd1, 32'h11,       24'h000000, 1'b0};
      tbl[16] = '{1'b0, 2'b00, 5'd0,  5'd0,  32'h0,        32'h0,    1'b0, 2'b00, 1'b0, 5'd1, 32'h11,       24'h000000, 1'b0};
      tbl[17] = '{1'b0, 2'b00, 5'd0,  5'd0,  32'h0,        32'h0,    1'b0, 2'b00, 1'b0, 5'd1, 32'h11,       24'h000000, 1'b0};

      @(posedge clk);
      #1;
      for (int i = 0; i < 18; i++) begin
         rst_n  = !tbl[i].rst;
         valid  = tbl[i].valid;
         sel[0] = tbl[i].s0;
         sel[1] = tbl[i].s1;
         dat[0] = tbl[i].d0;
         dat[1] = tbl[i].d1;
         hold   = tbl[i].hold;
         @(negedge clk);
         check($sformatf("vec%0d_ready", i),   64'(ready), 64'(tbl[i].e_rdy));
         check($sformatf("vec%0d_we", i),      64'(we),    64'(tbl[i].e_we));
         check($sformatf("vec%0d_select", i),  64'(wsel),  64'(tbl[i].e_sel));
         check($sformatf("vec%0d_data", i),    64'(wdat),  64'(tbl[i].e_dat));
         check($sformatf("vec%0d_pending", i), 64'(pend),  64'(tbl[i].e_pend));
         check($sformatf("vec%0d_full", i),    64'(full),  64'(tbl[i].e_full));
         if (tbl[i].rst) rst_n = 1'b1;
         @(posedge clk);
         #1;
      end

      // Hold/full: 6 offered under hold, 4 fit, then drain releases the rest in order.
      do_reset();
      k = 0;
      for (int c = 0; c < 6; c++) begin
         valid  = 2'b01;
         hold   = 1'b1;
         sel[0] = 5'(10 + k);
         dat[0] = 32'(256 + k);
         @(negedge clk);
         acc = ready[0];
         @(posedge clk);
         #1;
         if (acc) k++;
      end
      check("hold_accepts", 64'(k), 64'd4);
      sel[0] = 5'(10 + k);
      dat[0] = 32'(256 + k);
      @(negedge clk);
      check("hold_full",    64'(full),  64'd1);
      check("hold_ready",   64'(ready), 64'd0);
      check("hold_we",      64'(we),    64'd0);
      check("hold_pending", 64'(pend),  64'h3C00);
      hold = 1'b0;
      #1;
      check("release_ready", 64'(ready), 64'd1);
      got_sel.delete();
      got_dat.delete();
      for (int c = 0; c < 20; c++) begin
         if (we) begin
            got_sel.push_back(wsel);
            got_dat.push_back(wdat);
         end
         acc = ready[0];
         @(posedge clk);
         #1;
         if (acc) k++;
         valid  = (k < 6) ? 2'b01 : 2'b00;
         sel[0] = 5'(10 + k);
         dat[0] = 32'(256 + k);
         @(negedge clk);
      end
      check("drain_count",   64'(got_sel.size()), 64'd6);
      for (int i = 0; i < 6 && i < got_sel.size(); i++) begin
         check($sformatf("drain%0d_select", i), 64'(got_sel[i]), 64'(10 + i));
         check($sformatf("drain%0d_data", i),   64'(got_dat[i]), 64'(256 + i));
      end
      check("drain_pending", 64'(pend), 64'd0);
      check("drain_full",    64'(full), 64'd0);

      // Same-register ordering under hold.
      do_reset();
      for (int c = 0; c < 3; c++) begin
         valid  = 2'b01;
         hold   = 1'b1;
         sel[0] = 5'd7;
         dat[0] = 32'(c + 1);
         @(negedge clk);
         check($sformatf("ord_accept%0d", c), 64'(ready), 64'd1);
         @(posedge clk);
         #1;
      end
      valid = 2'b00;
      @(negedge clk);
      check("ord_pend_held", 64'(pend), 64'h80);
      hold = 1'b0;
      #1;
      got_sel.delete();
      got_dat.delete();
      nw = 0;
      for (int c = 0; c < 8; c++) begin
         check($sformatf("ord_pend7_c%0d", c), 64'(pend[7]), 64'((nw < 3) || we));
         if (we) begin
            got_sel.push_back(wsel);
            got_dat.push_back(wdat);
            nw++;
         end
         @(posedge clk);
         @(negedge clk);
      end
      check("ord_count", 64'(got_sel.size()), 64'd3);
      for (int i = 0; i < 3 && i < got_sel.size(); i++) begin
         check($sformatf("ord%0d_select", i), 64'(got_sel[i]), 64'd7);
         check($sformatf("ord%0d_data", i),   64'(got_dat[i]), 64'(i + 1));
      end

      // Mid-operation asynchronous reset with 3 queued and the output stage valid.
      do_reset();
      mid_sel[0] = 5'd3;
      mid_sel[1] = 5'd4;
      mid_sel[2] = 5'd6;
      mid_sel[3] = 5'd8;
      for (int c = 0; c < 4; c++) begin
         valid  = 2'b01;
         hold   = 1'b1;
         sel[0] = mid_sel[c];
         dat[0] = 32'(80 + c);
         @(posedge clk);
         #1;
      end
      valid = 2'b00;
      hold  = 1'b0;
      @(posedge clk);
      #1;
      hold = 1'b1;
      #2;
      check("mid_pre_we",      64'(we),   64'd1);
      check("mid_pre_pending", 64'(pend), 64'h158);
      valid = 2'b11;
      sel[0] = 5'd1;
      sel[1] = 5'd2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_we",      64'(we),    64'd0);
      check("mid_rst_select",  64'(wsel),  64'd0);
      check("mid_rst_data",    64'(wdat),  64'd0);
      check("mid_rst_pending", 64'(pend),  64'd0);
      check("mid_rst_full",    64'(full),  64'd0);
      check("mid_rst_ready",   64'(ready), 64'd0);
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_ready_held", 64'(ready), 64'd0);
      valid = 2'b00;
      hold  = 1'b0;
      rst_n = 1'b1;
      bad_we = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (we) bad_we++;
      end
      check("mid_post_no_write", 64'(bad_we), 64'd0);
      @(posedge clk);
      #1;
      valid = 2'b11;
      @(negedge clk);
      check("mid_post_grant", 64'(ready), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
